// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and defaults for the MULT/DIV sequencer
// Holds the controller state encoding, the op encoding and the watchdog default.
package muldiv_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, CLR = 2'd1, RUN = 2'd2} state_t;
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV = 1'b1;
    localparam int DEF_MAX_CYCLES = 40;
endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: CPU-side request/response bundle of muldiv_ctrl
// Request: op_valid, op_div, op_a, op_b (from the control unit).
// Response: op_ready, busy, done, div_zero, timeout, hi, lo (to the control unit).
// master = control unit side, slave = sequencer side.
interface muldiv_ctrl_if;
    logic        op_valid;
    logic        op_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_ready;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        timeout;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (
        output op_valid, op_div, op_a, op_b,
        input  op_ready, busy, done, div_zero, timeout, hi, lo
    );
    modport slave (
        input  op_valid, op_div, op_a, op_b,
        output op_ready, busy, done, div_zero, timeout, hi, lo
    );
endinterface

// File: rtl/muldiv_watchdog.sv
// muldiv_watchdog: RUN-cycle counter that flags the last allowed cycle
// Ports: clock, reset (async active-low), clr (sync clear), en (count enable),
// expire (high while the count sits on the MAX_CYCLES-th cycle).
module muldiv_watchdog import muldiv_pkg::*; #(
    parameter int MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int CNT_W = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [CNT_W-1:0] cnt;
    // Count 0 is the first enabled cycle, so expiry lands on cycle MAX_CYCLES.
    assign expire = cnt == CNT_W'(MAX_CYCLES - 1);
    always_ff @(posedge clock or negedge reset)
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expire)
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer driving the iterative multiplier and divider units
// Ports: clock, reset (async active-low); bus (muldiv_ctrl_if.slave, CPU side);
// mult_clr/div_clr, mult_ctrl/div_ctrl (unit clear / run enable);
// unit_a/unit_b (latched operands); mult_end/div_end, mult_hi/lo, div_hi/lo (unit results).
// Build option MULDIV_DIV_ZERO_EXC_EN: a DIV by zero completes at once with div_zero.
module muldiv_ctrl import muldiv_pkg::*; #(
    parameter int MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int CNT_W = 6
) (
    input  logic        clock,
    input  logic        reset,
    muldiv_ctrl_if.slave bus,
    output logic        mult_clr,
    output logic        div_clr,
    output logic        mult_ctrl,
    output logic        div_ctrl,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic        mult_end,
    input  logic        div_end,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo
);
    state_t state, state_nxt;
    logic op_div_q, accept, dz, sel_end, expire, fin, tmo;
    logic done_q, dz_q, to_q;
    logic [31:0] hi_q, lo_q;
    assign accept = state == IDLE && bus.op_valid;
`ifdef MULDIV_DIV_ZERO_EXC_EN
    assign dz = accept && bus.op_div == OP_DIV && bus.op_b == '0;
`else
    assign dz = 1'b0;
`endif
    assign sel_end = op_div_q == OP_DIV ? div_end : mult_end;
    assign fin = sel_end || expire;
    // End seen in the expiry cycle counts as a normal completion.
    assign tmo = state == RUN && !sel_end && expire;
    muldiv_watchdog #(.MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)) u_wdog (
        .clock (clock),
        .reset (reset),
        .clr   (state == CLR),
        .en    (state == RUN),
        .expire(expire)
    );
    always_ff @(posedge clock or negedge reset)
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    always_comb begin
        state_nxt = state == IDLE ? (accept && !dz ? CLR : IDLE) :
                    state == CLR  ? RUN :
                    state == RUN  ? (fin ? IDLE : RUN) : IDLE;
    end
    // Run enables drop combinationally on end so a unit never re-arms;
    // to_q re-clears the stuck unit in the cycle the timeout is reported.
    always_comb begin
        mult_ctrl = state == RUN && op_div_q == OP_MULT && !mult_end;
        div_ctrl  = state == RUN && op_div_q == OP_DIV && !div_end;
        mult_clr  = op_div_q == OP_MULT && (state == CLR || to_q);
        div_clr   = op_div_q == OP_DIV && (state == CLR || to_q);
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            {op_div_q, done_q, dz_q, to_q} <= '0;
            {unit_a, unit_b, hi_q, lo_q} <= '0;
        end else begin
            done_q <= dz || (state == RUN && fin);
            dz_q   <= dz;
            to_q   <= tmo;
            if (accept) begin
                op_div_q <= bus.op_div;
                unit_a   <= bus.op_a;
                unit_b   <= bus.op_b;
            end
            if (state == RUN && sel_end) begin
                hi_q <= op_div_q == OP_DIV ? div_hi : mult_hi;
                lo_q <= op_div_q == OP_DIV ? div_lo : mult_lo;
            end
        end
    assign bus.op_ready = state == IDLE;
    assign bus.busy     = state != IDLE;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.timeout  = to_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl
// Behavioural unit models answer after LAT run cycles with a sticky end flag.
module tb_muldiv_ctrl;
    localparam int LAT = 33;
    logic clock, reset;
    logic mult_clr, div_clr, mult_ctrl, div_ctrl;
    logic [31:0] unit_a, unit_b;
    logic m_end = 1'b0, d_end = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, d_hi = '0, d_lo = '0;
    int m_cnt = 0, d_cnt = 0;
    logic stuck = 1'b0;
    logic signed [63:0] prod;
    int checks = 0, errors = 0;
    int done_cnt = 0, mclr_cnt = 0, mctrl_cnt = 0, dclr_cnt = 0, dctrl_cnt = 0;
    int n, s0, s1;

    muldiv_ctrl_if b();

    muldiv_ctrl dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (b),
        .mult_clr (mult_clr),
        .div_clr  (div_clr),
        .mult_ctrl(mult_ctrl),
        .div_ctrl (div_ctrl),
        .unit_a   (unit_a),
        .unit_b   (unit_b),
        .mult_end (m_end),
        .div_end  (d_end),
        .mult_hi  (m_hi),
        .mult_lo  (m_lo),
        .div_hi   (d_hi),
        .div_lo   (d_lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign prod = $signed({{32{unit_a[31]}}, unit_a}) * $signed({{32{unit_b[31]}}, unit_b});

    always @(posedge clock) begin
        if (mult_clr) begin
            m_cnt <= 0;
            m_end <= 1'b0;
        end else if (mult_ctrl && !stuck) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == LAT - 1) begin
                m_end <= 1'b1;
                m_hi  <= prod[63:32];
                m_lo  <= prod[31:0];
            end
        end
    end

    always @(posedge clock) begin
        if (div_clr) begin
            d_cnt <= 0;
            d_end <= 1'b0;
        end else if (div_ctrl) begin
            d_cnt <= d_cnt + 1;
            if (d_cnt == LAT - 1) begin
                d_end <= 1'b1;
                d_hi  <= unit_b == 0 ? unit_a : unit_a % unit_b;
                d_lo  <= unit_b == 0 ? 32'hFFFFFFFF : unit_a / unit_b;
            end
        end
    end

    always @(negedge clock) begin
        if (b.done) done_cnt++;
        if (mult_clr) mclr_cnt++;
        if (mult_ctrl) mctrl_cnt++;
        if (div_clr) dclr_cnt++;
        if (div_ctrl) dctrl_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic div, input logic [31:0] a, input logic [31:0] bb);
        b.op_valid = 1'b1;
        b.op_div = div;
        b.op_a = a;
        b.op_b = bb;
        @(negedge clock);
        b.op_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int steps);
        steps = 0;
        do begin
            @(negedge clock);
            steps++;
        end while (!b.done && steps < bound);
        chk("done_seen", 32'(b.done), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        b.op_valid = 1'b0;
        b.op_div = 1'b0;
        b.op_a = '0;
        b.op_b = '0;
        repeat (2) @(negedge clock);
        chk("rst_ready", 32'(b.op_ready), 32'd1);
        chk("rst_busy", 32'(b.busy), 32'd0);
        chk("rst_done", 32'(b.done), 32'd0);
        chk("rst_flags", {30'd0, b.div_zero, b.timeout}, 32'd0);
        chk("rst_hi", b.hi, 32'd0);
        chk("rst_lo", b.lo, 32'd0);
        chk("rst_unit_a", unit_a, 32'd0);
        chk("rst_unit_b", unit_b, 32'd0);
        chk("rst_unit_ctl", {28'd0, mult_clr, div_clr, mult_ctrl, div_ctrl}, 32'd0);
        reset = 1'b1;

        issue(1'b0, 32'd3, 32'hFFFFFFFC);
        chk("mul_clr_cyc", {30'd0, mult_clr, mult_ctrl}, 32'b10);
        chk("mul_busy", {30'd0, b.busy, b.op_ready}, 32'b10);
        chk("mul_unit_a", unit_a, 32'd3);
        chk("mul_unit_b", unit_b, 32'hFFFFFFFC);
        @(negedge clock);
        chk("mul_run_cyc", {29'd0, mult_clr, mult_ctrl, div_ctrl}, 32'b010);
        wait_done(60, n);
        chk("mul_latency", 32'(n), 32'd34);
        chk("mul_hi", b.hi, 32'hFFFFFFFF);
        chk("mul_lo", b.lo, 32'hFFFFFFF4);
        chk("mul_timeout", 32'(b.timeout), 32'd0);
        chk("mul_ready", 32'(b.op_ready), 32'd1);
        @(negedge clock);
        chk("mul_done_pulse", 32'(b.done), 32'd0);
        chk("mul_hi_hold", b.hi, 32'hFFFFFFFF);

        s0 = mctrl_cnt;
        issue(1'b1, 32'd7, 32'd2);
        chk("div_clr_cyc", {30'd0, div_clr, mult_clr}, 32'b10);
        @(negedge clock);
        chk("div_run_cyc", {30'd0, div_ctrl, mult_ctrl}, 32'b10);
        wait_done(60, n);
        chk("div_latency", 32'(n), 32'd34);
        chk("div_lo", b.lo, 32'd3);
        chk("div_hi", b.hi, 32'd1);
        chk("div_zero_flag", 32'(b.div_zero), 32'd0);
        @(negedge clock);
        chk("div_no_mult_ctrl", 32'(mctrl_cnt - s0), 32'd0);

        s0 = dctrl_cnt;
        s1 = dclr_cnt;
        issue(1'b1, 32'd9, 32'd0);
`ifdef MULDIV_DIV_ZERO_EXC_EN
        chk("dz_done", {30'd0, b.done, b.div_zero}, 32'b11);
        chk("dz_busy", 32'(b.busy), 32'd0);
        chk("dz_hi", b.hi, 32'd1);
        chk("dz_lo", b.lo, 32'd3);
        @(negedge clock);
        chk("dz_pulse", {30'd0, b.done, b.div_zero}, 32'b00);
        chk("dz_no_div_ctrl", 32'(dctrl_cnt - s0), 32'd0);
        chk("dz_no_div_clr", 32'(dclr_cnt - s1), 32'd0);
`else
        chk("dz_clr_cyc", 32'(div_clr), 32'd1);
        @(negedge clock);
        wait_done(60, n);
        chk("dz_div_zero", 32'(b.div_zero), 32'd0);
        chk("dz_hi", b.hi, 32'd9);
        chk("dz_lo", b.lo, 32'hFFFFFFFF);
        @(negedge clock);
        chk("dz_div_ran", 32'(dctrl_cnt - s0), 32'(LAT));
`endif

        s0 = done_cnt;
        b.op_valid = 1'b1;
        b.op_div = 1'b0;
        b.op_a = 32'd2;
        b.op_b = 32'd3;
        @(negedge clock);
        b.op_a = 32'd4;
        b.op_b = 32'd5;
        chk("b2b_first_a", unit_a, 32'd2);
        chk("b2b_not_ready", 32'(b.op_ready), 32'd0);
        wait_done(60, n);
        chk("b2b_first_lo", b.lo, 32'd6);
        chk("b2b_ready_in_done", 32'(b.op_ready), 32'd1);
        @(negedge clock);
        b.op_valid = 1'b0;
        chk("b2b_second_a", unit_a, 32'd4);
        chk("b2b_second_busy", 32'(b.busy), 32'd1);
        @(negedge clock);
        wait_done(60, n);
        chk("b2b_second_lo", b.lo, 32'd20);
        chk("b2b_second_hi", b.hi, 32'd0);
        @(negedge clock);
        chk("b2b_done_count", 32'(done_cnt - s0), 32'd2);

        stuck = 1'b1;
        s0 = mclr_cnt;
        issue(1'b0, 32'd7, 32'd7);
        wait_done(60, n);
        chk("to_latency", 32'(n), 32'd41);
        chk("to_flags", {30'd0, b.timeout, b.div_zero}, 32'b10);
        chk("to_hi", b.hi, 32'd0);
        chk("to_lo", b.lo, 32'd20);
        chk("to_clr", {30'd0, mult_clr, mult_ctrl}, 32'b10);
        @(negedge clock);
        chk("to_pulse", {29'd0, b.done, b.timeout, mult_clr}, 32'b000);
        chk("to_clr_count", 32'(mclr_cnt - s0), 32'd2);
        stuck = 1'b0;

        s0 = done_cnt;
        issue(1'b0, 32'd9, 32'd9);
        repeat (10) @(negedge clock);
        chk("rr_running", 32'(mult_ctrl), 32'd1);
        reset = 1'b0;
        #1;
        chk("rr_ready", {30'd0, b.op_ready, b.busy}, 32'b10);
        chk("rr_hi", b.hi, 32'd0);
        chk("rr_lo", b.lo, 32'd0);
        chk("rr_unit_a", unit_a, 32'd0);
        chk("rr_unit_ctl", {28'd0, mult_clr, div_clr, mult_ctrl, div_ctrl}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        chk("rr_no_done", 32'(done_cnt - s0), 32'd0);
        issue(1'b0, 32'd5, 32'd6);
        @(negedge clock);
        wait_done(60, n);
        chk("rr_next_lo", b.lo, 32'd30);
        chk("rr_next_hi", b.hi, 32'd0);
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer between the CPU control unit and the iterative `booth_mult` / divider datapaths. It accepts one MULT or DIV request at a time and latches the operands. It clears and starts the selected unit, waits for that unit's end flag, then captures HI/LO into the architectural HI/LO registers. It reports completion, divide-by-zero and timeout to the control unit.

## Interface
- `MAX_CYCLES`, 40: RUN cycles allowed before the timeout abort; must be ≥ 34.
- `CNT_W`, 6: width of the watchdog counter; must hold `MAX_CYCLES`.
- `clock` in 1: rising-edge clock, sole clock domain.
- `reset` in 1: asynchronous, active-low reset.
- `op_valid` in 1: request strobe.
- `op_div` in 1: 0 = MULT, 1 = DIV.
- `op_a`, `op_b` in 32: multiplicand/dividend and multiplier/divisor.
- `op_ready` out 1: high only in IDLE.
- `busy` out 1: high in CLR and RUN.
- `done` out 1: one-cycle completion pulse.
- `div_zero` out 1: qualifies `done`; divisor was zero.
- `timeout` out 1: qualifies `done`; unit never ended.
- `hi`, `lo` out 32: architectural HI/LO registers.
- `mult_clr`, `div_clr` out 1: active-high synchronous clear to each unit's `reset`.
- `mult_ctrl`, `div_ctrl` out 1: run enable to each unit.
- `unit_a`, `unit_b` out 32: latched operands, shared by both units.
- `mult_end`, `div_end` in 1: unit end flags.
- `mult_hi`, `mult_lo`, `div_hi`, `div_lo` in 32: unit results; DIV gives HI = remainder, LO = quotient.

## Operation
- States: IDLE, CLR, RUN.
- **IDLE**
  - `op_ready` = 1.
  - On `op_valid`: latch `op_a`/`op_b` into `unit_a`/`unit_b` and latch `op_div`, then go to CLR.
  - `op_valid` is ignored in every other state; no queueing.
- **CLR**, exactly one cycle.
  - Assert the selected unit's `*_clr`.
  - Clear the watchdog, then go to RUN.
  - This removes any stale end flag left from a previous operation.
- **RUN**
  - `*_ctrl` = (state == RUN) && !`*_end`. This is combinational, so the unit never re-arms in the cycle its end is seen.
  - On the selected `*_end` = 1: capture unit HI/LO into `hi`/`lo`, pulse `done`, go to IDLE.
- **Watchdog**
  - Counts RUN cycles.
  - At `MAX_CYCLES` with no end: `hi`/`lo` unchanged, pulse `done` with `timeout` = 1, assert the selected `*_clr` for one cycle, go to IDLE.
- The unselected unit's `*_ctrl` and `*_clr` stay 0 throughout.
- `div_zero` and `timeout` are meaningful only while `done` = 1; otherwise they are 0.
- The arithmetic is the unit's; `hi`/`lo` are raw copies with no sign or width transformation.

## Timing
- Reset values: state IDLE, `hi`/`lo` = 0, `unit_a`/`unit_b` = 0, `done`/`div_zero`/`timeout`/`busy` = 0, all `*_clr`/`*_ctrl` = 0, `op_ready` = 1.
- Request accepted at edge E0. CLR occupies the cycle after E0; RUN starts at E1.
- `done` is registered: high during the cycle after the edge that samples `*_end` = 1. `hi`/`lo` are valid in that same cycle and hold until the next successful operation.
- A new `op_valid` may be presented in the `done` cycle; state is already IDLE there.
- Reset asserted mid-operation: immediate return to reset values. No `done` is produced, and the units are left to their own reset.
- An end flag from the unselected unit is ignored.
- End arriving in the same cycle the watchdog expires: normal completion wins and `timeout` = 0.

## Configuration
- Macro: `MULDIV_DIV_ZERO_EXC_EN`.
- **Defined:** a DIV accepted with `op_b` == 0 skips CLR/RUN.
  - Next cycle: `done` = 1, `div_zero` = 1, `hi`/`lo` unchanged.
  - No `div_clr` or `div_ctrl` activity.
- **Undefined:** the divisor is not checked; the divider runs normally and `div_zero` is tied to 0.

## Structure
- Shared package `muldiv_pkg` holds:
  - state encoding IDLE/CLR/RUN;
  - the op encoding (0 = MULT, 1 = DIV);
  - the `MAX_CYCLES` default.
- One sub-module: `muldiv_watchdog`, a counter with clear, enable and expire output, parameterised by `MAX_CYCLES`/`CNT_W`.
- The controller itself stays a single FSM with the HI/LO output registers.

## Test plan
- **MULT:** `op_a` = 3, `op_b` = 0xFFFFFFFC → `done` with `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFF4; `timeout` = 0; `mult_clr` high exactly one cycle before `mult_ctrl` rises.
- **DIV:** `op_a` = 7, `op_b` = 2 → `lo` = 3, `hi` = 1; `mult_ctrl` never asserted.
- **DIV with `op_b` = 0, macro defined:** `done` + `div_zero` one cycle after accept; `hi`/`lo` keep the previous values 1/3; `div_ctrl` stays 0. Macro undefined: divider runs and `div_zero` = 0.
- **Back-to-back:** second `op_valid` held during busy is ignored; it is accepted in the `done` cycle; two `done` pulses total.
- **Stuck end:** `mult_end` forced 0 → `done` + `timeout` after 40 RUN cycles, one `mult_clr` pulse, `hi`/`lo` unchanged.
- **Reset mid-RUN:** `reset` low for one cycle at RUN cycle 10 → all outputs at reset values, no `done`; next MULT 5×6 gives `lo` = 30.
